// File: rtl/approx_mult_error_monitor.sv
// rtl/approx_mult_error_monitor.sv - error-distance statistics monitor for an approximate multiplier
module approx_mult_error_monitor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16,
    parameter int SUM_W = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_samples,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_x,
    input  logic [2*WIDTH-1:0]   approx_y,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [SUM_W-1:0]     err_sum,
    output logic [2*WIDTH-1:0]   err_max,
    output logic [WIDTH-1:0]     max_a,
    output logic [WIDTH-1:0]     max_x
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   target;
    logic [CNT_W-1:0]   accepted;
    logic [CNT_W-1:0]   accepted_nxt;
    logic               accept;
    logic               start_take;

    logic [PW-1:0]      exact;
    logic [PW-1:0]      ed;

    logic               s1_valid;
    logic [PW-1:0]      s1_ed;
    logic               s1_nz;
    logic [WIDTH-1:0]   s1_a;
    logic [WIDTH-1:0]   s1_x;
    logic [SUM_W:0]     sum_ext;

    assign accept       = in_valid & in_ready;
    assign accepted_nxt = accepted + 1'b1;
    assign start_take   = start & ((state == S_IDLE) | (state == S_DONE));

    always_comb begin
        exact = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_x};
        ed    = (exact >= approx_y) ? (exact - approx_y) : (approx_y - exact);
    end

    // One extra bit catches the carry out so the sum can clamp instead of wrapping
    assign sum_ext = {1'b0, err_sum} + {{(SUM_W + 1 - PW){1'b0}}, s1_ed};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            target   <= '0;
            accepted <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        target   <= num_samples;
                        accepted <= '0;
                        if (num_samples != '0) begin
                            state    <= S_RUN;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                        end else begin
                            state    <= S_DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        accepted <= accepted_nxt;
                        if (accepted_nxt == target) begin
                            state    <= S_DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!s1_valid) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_ed      <= '0;
            s1_nz      <= 1'b0;
            s1_a       <= '0;
            s1_x       <= '0;
            sample_cnt <= '0;
            err_cnt    <= '0;
            err_sum    <= '0;
            err_max    <= '0;
            max_a      <= '0;
            max_x      <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_ed <= ed;
                s1_nz <= (ed != '0);
                s1_a  <= op_a;
                s1_x  <= op_x;
            end

            if (s1_valid) begin
                sample_cnt <= sample_cnt + 1'b1;
                err_cnt    <= err_cnt + {{(CNT_W - 1){1'b0}}, s1_nz};
                err_sum    <= sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
                // Strict compare keeps the first sample that hit the maximum
                if (s1_ed > err_max) begin
                    err_max <= s1_ed;
                    max_a   <= s1_a;
                    max_x   <= s1_x;
                end
            end

            // A start is only honoured with the pipeline empty, so clearing here never drops a sample
            if (start_take) begin
                sample_cnt <= '0;
                err_cnt    <= '0;
                err_sum    <= '0;
                err_max    <= '0;
                max_a      <= '0;
                max_x      <= '0;
            end
        end
    end

endmodule
